// File: rtl/unidad_cortocircuito_pkg.sv
// Shared definitions for the EX-stage forwarding unit.
//   NO_CORTO / CORTO_WB / CORTO_MEM : operand-mux select encodings
//   corto_sel_t                     : 2-bit select type
//   REG_W                           : register-index width
package unidad_cortocircuito_pkg;

  localparam int unsigned REG_W = 5;

  typedef logic [1:0] corto_sel_t;

  localparam corto_sel_t NO_CORTO  = 2'b00;
  localparam corto_sel_t CORTO_WB  = 2'b01;
  localparam corto_sel_t CORTO_MEM = 2'b10;

endpackage

// File: rtl/unidad_cortocircuito_fwd_select.sv
// Forwarding select for a single EX-stage source operand.
// Ports:
//   src             : source register index of the EX instruction
//   i_rd_MEM/i_rd_WB: destination registers in MEM and WB
//   i_write_reg_*   : register-file write enables of MEM and WB
//   o_corto         : operand-mux select (MEM beats WB, register 0 never forwards)
module fwd_select
  import unidad_cortocircuito_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] i_rd_MEM,
  input  logic [REG_W-1:0] i_rd_WB,
  input  logic             i_write_reg_MEM,
  input  logic             i_write_reg_WB,
  output corto_sel_t       o_corto
);

  logic mem_hit;
  logic wb_hit;

  always_comb begin
    mem_hit = i_write_reg_MEM && (i_rd_MEM == src) && (i_rd_MEM != '0);
    wb_hit  = i_write_reg_WB  && (i_rd_WB  == src) && (i_rd_WB  != '0);
    o_corto = NO_CORTO;
    // MEM holds the younger producer, so it wins over WB.
    if (mem_hit) begin
      o_corto = CORTO_MEM;
    end else if (wb_hit) begin
      o_corto = CORTO_WB;
    end
  end

endmodule

// File: rtl/unidad_cortocircuito.sv
// EX-stage forwarding (bypass) unit for the 5-stage MIPS pipeline.
// Ports:
//   i_clk, i_rst_n           : clock / async active-low reset (statistics only)
//   i_rd_MEM, i_rd_WB        : destination registers in MEM and WB
//   i_rs_EX, i_rt_EX         : source registers of the EX instruction
//   i_write_reg_MEM/_WB      : register-file write enables
//   i_stats_clr              : synchronous counter clear
//   o_corto_rs, o_corto_rt   : combinational operand-mux selects
//   o_fwd_mem_count/_wb_count: saturating forwarding-event counters
// Build option: define CORTOCIRCUITO_STATS_EN to build the counters; otherwise they read 0.
module unidad_cortocircuito
  import unidad_cortocircuito_pkg::*;
#(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [4:0]         i_rd_MEM,
  input  logic [4:0]         i_rd_WB,
  input  logic [4:0]         i_rs_EX,
  input  logic [4:0]         i_rt_EX,
  input  logic               i_write_reg_MEM,
  input  logic               i_write_reg_WB,
  input  logic               i_stats_clr,
  output logic [1:0]         o_corto_rs,
  output logic [1:0]         o_corto_rt,
  output logic [COUNT_W-1:0] o_fwd_mem_count,
  output logic [COUNT_W-1:0] o_fwd_wb_count
);

  fwd_select u_fwd_rs (
    .src             (i_rs_EX),
    .i_rd_MEM        (i_rd_MEM),
    .i_rd_WB         (i_rd_WB),
    .i_write_reg_MEM (i_write_reg_MEM),
    .i_write_reg_WB  (i_write_reg_WB),
    .o_corto         (o_corto_rs)
  );

  fwd_select u_fwd_rt (
    .src             (i_rt_EX),
    .i_rd_MEM        (i_rd_MEM),
    .i_rd_WB         (i_rd_WB),
    .i_write_reg_MEM (i_write_reg_MEM),
    .i_write_reg_WB  (i_write_reg_WB),
    .o_corto         (o_corto_rt)
  );

`ifdef CORTOCIRCUITO_STATS_EN
  logic [1:0]         mem_inc, wb_inc;
  logic [COUNT_W+1:0] mem_sum, wb_sum;
  logic [COUNT_W-1:0] mem_cnt_q, mem_cnt_d;
  logic [COUNT_W-1:0] wb_cnt_q, wb_cnt_d;

  always_comb begin
    mem_inc = {1'b0, o_corto_rs == CORTO_MEM} + {1'b0, o_corto_rt == CORTO_MEM};
    wb_inc  = {1'b0, o_corto_rs == CORTO_WB}  + {1'b0, o_corto_rt == CORTO_WB};
    // Two guard bits catch any carry past all-ones; clamp instead of wrapping.
    mem_sum = {2'b00, mem_cnt_q} + {{COUNT_W{1'b0}}, mem_inc};
    wb_sum  = {2'b00, wb_cnt_q}  + {{COUNT_W{1'b0}}, wb_inc};
    mem_cnt_d = (|mem_sum[COUNT_W+1:COUNT_W]) ? '1 : mem_sum[COUNT_W-1:0];
    wb_cnt_d  = (|wb_sum[COUNT_W+1:COUNT_W])  ? '1 : wb_sum[COUNT_W-1:0];
    if (i_stats_clr) begin
      mem_cnt_d = '0;
      wb_cnt_d  = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_cnt_q <= '0;
      wb_cnt_q  <= '0;
    end else begin
      mem_cnt_q <= mem_cnt_d;
      wb_cnt_q  <= wb_cnt_d;
    end
  end

  assign o_fwd_mem_count = mem_cnt_q;
  assign o_fwd_wb_count  = wb_cnt_q;
`else
  logic unused_stats;
  assign unused_stats    = ^{i_clk, i_rst_n, i_stats_clr};
  assign o_fwd_mem_count = '0;
  assign o_fwd_wb_count  = '0;
`endif

endmodule

// File: tb/tb_unidad_cortocircuito.sv
// Self-checking bench for unidad_cortocircuito: directed test-plan steps, randomized
// selects against a register-ownership model, and (stats build) counter checks.
module tb_unidad_cortocircuito;

  localparam int unsigned COUNT_W = 16;
  localparam logic [1:0] NC = 2'b00, WB = 2'b01, MEM = 2'b10;

  logic               i_clk = 1'b0;
  logic               i_rst_n;
  logic [4:0]         i_rd_MEM, i_rd_WB, i_rs_EX, i_rt_EX;
  logic               i_write_reg_MEM, i_write_reg_WB, i_stats_clr;
  logic [1:0]         o_corto_rs, o_corto_rt;
  logic [COUNT_W-1:0] o_fwd_mem_count, o_fwd_wb_count;

  int n_checks = 0;
  int n_fail   = 0;

  unidad_cortocircuito #(.COUNT_W(COUNT_W)) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_rd_MEM        (i_rd_MEM),
    .i_rd_WB         (i_rd_WB),
    .i_rs_EX         (i_rs_EX),
    .i_rt_EX         (i_rt_EX),
    .i_write_reg_MEM (i_write_reg_MEM),
    .i_write_reg_WB  (i_write_reg_WB),
    .i_stats_clr     (i_stats_clr),
    .o_corto_rs      (o_corto_rs),
    .o_corto_rt      (o_corto_rt),
    .o_fwd_mem_count (o_fwd_mem_count),
    .o_fwd_wb_count  (o_fwd_wb_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: build the "who produces the newest value of each register" table, then look up.
  function automatic logic [1:0] ref_sel(input logic [4:0] src, input logic [4:0] rd_mem,
                                         input logic wr_mem, input logic [4:0] rd_wb,
                                         input logic wr_wb);
    logic [1:0] owner [32];
    for (int r = 0; r < 32; r++) owner[r] = NC;
    if (wr_wb) owner[rd_wb] = WB;
    if (wr_mem) owner[rd_mem] = MEM;
    owner[0] = NC;
    return owner[src];
  endfunction

  task automatic drive(input logic [4:0] rd_mem, input logic wr_mem, input logic [4:0] rd_wb,
                       input logic wr_wb, input logic [4:0] rs, input logic [4:0] rt);
    i_rd_MEM = rd_mem; i_write_reg_MEM = wr_mem;
    i_rd_WB = rd_wb;   i_write_reg_WB = wr_wb;
    i_rs_EX = rs;      i_rt_EX = rt;
  endtask

  task automatic step(input string tag, input logic [4:0] rd_mem, input logic wr_mem,
                      input logic [4:0] rd_wb, input logic wr_wb, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [1:0] exp_rs, input logic [1:0] exp_rt);
    drive(rd_mem, wr_mem, rd_wb, wr_wb, rs, rt);
    #1;
    chk({tag, "_rs"}, 32'(o_corto_rs), 32'(exp_rs));
    chk({tag, "_rt"}, 32'(o_corto_rt), 32'(exp_rt));
  endtask

  function automatic logic [4:0] rnd_reg();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
  endfunction

`ifdef CORTOCIRCUITO_STATS_EN
  int exp_mem, exp_wb;
`endif

  initial begin
    i_rst_n = 1'b0;
    i_stats_clr = 1'b1;
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    #1;
    chk("reset_mem_cnt", 32'(o_fwd_mem_count), 32'd0);
    chk("reset_wb_cnt", 32'(o_fwd_wb_count), 32'd0);
    // Selects are valid while reset is held.
    step("in_reset_wb", 5'd0, 1'b0, 5'd4, 1'b1, 5'd4, 5'd0, WB, NC);
    step("all_zero", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, NC, NC);
    i_rst_n = 1'b1;

    step("wb2_rs", 5'd0, 1'b0, 5'd2, 1'b1, 5'd2, 5'd0, WB, NC);
    step("wb2_both", 5'd0, 1'b0, 5'd2, 1'b1, 5'd2, 5'd2, WB, WB);
    step("wb2_none", 5'd0, 1'b0, 5'd2, 1'b1, 5'd1, 5'd3, NC, NC);
    step("mem3_rt", 5'd3, 1'b1, 5'd2, 1'b1, 5'd1, 5'd3, NC, MEM);
    step("mem3_both", 5'd3, 1'b1, 5'd2, 1'b1, 5'd3, 5'd3, MEM, MEM);
    step("split_a", 5'd8, 1'b1, 5'd30, 1'b1, 5'd30, 5'd8, WB, MEM);
    step("split_b", 5'd20, 1'b1, 5'd27, 1'b1, 5'd20, 5'd27, MEM, WB);
    step("prio_mem", 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 5'd0, MEM, NC);
    step("reg0", 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0, NC, NC);
    step("mem_nowrite", 5'd9, 1'b0, 5'd9, 1'b1, 5'd9, 5'd9, WB, WB);

    for (int i = 0; i < 300; i++) begin
      logic [4:0] rm, rw, rs, rt;
      logic wm, ww;
      rm = rnd_reg(); rw = rnd_reg(); rs = rnd_reg(); rt = rnd_reg();
      wm = 1'($urandom); ww = 1'($urandom);
      step("rand", rm, wm, rw, ww, rs, rt, ref_sel(rs, rm, wm, rw, ww), ref_sel(rt, rm, wm, rw, ww));
    end

`ifdef CORTOCIRCUITO_STATS_EN
    // Clear, then three cycles of double MEM forwarding.
    @(negedge i_clk);
    i_stats_clr = 1'b1;
    @(negedge i_clk);
    chk("clr_mem", 32'(o_fwd_mem_count), 32'd0);
    i_stats_clr = 1'b0;
    drive(5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 5'd7);
    repeat (3) @(negedge i_clk);
    chk("mem_x3", 32'(o_fwd_mem_count), 32'd6);
    chk("wb_x3", 32'(o_fwd_wb_count), 32'd0);
    #2 i_rst_n = 1'b0;
    #1;
    chk("async_rst", 32'(o_fwd_mem_count), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Randomized counting against integer counters.
    exp_mem = 0; exp_wb = 0;
    for (int i = 0; i < 60; i++) begin
      logic [4:0] rm, rw, rs, rt;
      logic wm, ww;
      logic [1:0] sr, st;
      rm = rnd_reg(); rw = rnd_reg(); rs = rnd_reg(); rt = rnd_reg();
      wm = 1'($urandom); ww = 1'($urandom);
      drive(rm, wm, rw, ww, rs, rt);
      sr = ref_sel(rs, rm, wm, rw, ww);
      st = ref_sel(rt, rm, wm, rw, ww);
      exp_mem += int'(sr == MEM) + int'(st == MEM);
      exp_wb  += int'(sr == WB) + int'(st == WB);
      @(negedge i_clk);
      chk("rand_mem_cnt", 32'(o_fwd_mem_count), 32'(exp_mem));
      chk("rand_wb_cnt", 32'(o_fwd_wb_count), 32'(exp_wb));
    end

    // Clear overrides an increment.
    i_stats_clr = 1'b1;
    drive(5'd7, 1'b1, 5'd6, 1'b1, 5'd7, 5'd6);
    @(negedge i_clk);
    chk("clr_override_mem", 32'(o_fwd_mem_count), 32'd0);
    chk("clr_override_wb", 32'(o_fwd_wb_count), 32'd0);
    i_stats_clr = 1'b0;

    // Drive to saturation with +2 per cycle: 2^16 is passed after 32768 cycles.
    drive(5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 5'd7);
    repeat (32767) @(negedge i_clk);
    chk("near_sat", 32'(o_fwd_mem_count), 32'hFFFE);
    @(negedge i_clk);
    chk("sat_hit", 32'(o_fwd_mem_count), 32'hFFFF);
    repeat (3) @(negedge i_clk);
    chk("sat_hold", 32'(o_fwd_mem_count), 32'hFFFF);
    chk("sat_wb", 32'(o_fwd_wb_count), 32'd0);
`else
    i_stats_clr = 1'b0;
    drive(5'd7, 1'b1, 5'd6, 1'b1, 5'd7, 5'd6);
    repeat (4) @(negedge i_clk);
    chk("tied_mem", 32'(o_fwd_mem_count), 32'd0);
    chk("tied_wb", 32'(o_fwd_wb_count), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
